// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer
// Converts a camera-style pixel stream (FVAL/LVAL/DVAL) into write strobes
// for one write port of the SDRAM controller. Each frame is preceded by a
// load/clear pulse so it starts at the programmed base address with an
// empty FIFO. Pixels outside the active window are dropped. A sticky flag
// records pixels lost to a full FIFO.
//
// Build option: define SFW_TEST_PATTERN_EN to replace pixel data with
// {y[7:0], x[7:0]} of each written pixel (iDATA ignored).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | capture disabled, waiting for iSTART
// WAIT_VB  | armed; waiting for vertical blank (registered FVAL low)
// LOAD     | oWR_LOAD held high for LOAD_CYCLES cycles
// WAIT_SOF | waiting for registered FVAL rising edge
// ACTIVE   | frame in progress; qualified pixels are written

module sdram_frame_writer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOAD_CYCLES = 4,
  parameter int DSIZE       = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             iSTART,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic             iDVAL,
  input  logic [DSIZE-1:0] iDATA,
  input  logic             iFIFO_FULL,
  output logic             oWR,
  output logic [DSIZE-1:0] oWR_DATA,
  output logic             oWR_LOAD,
  output logic [10:0]      oX_CNT,
  output logic [10:0]      oY_CNT,
  output logic [15:0]      oFRAME_CNT,
  output logic             oOVERFLOW,
  output logic             oBUSY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_VB  = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_WAIT_SOF = 3'd3;
  localparam logic [2:0] S_ACTIVE   = 3'd4;

  localparam logic [10:0] X_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIM     = 11'(V_ACTIVE);
  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic [3:0]  LOAD_INIT = 4'(LOAD_CYCLES - 1);

  logic [2:0]       state;
  logic [3:0]       load_cnt;
  logic             fval_r, lval_r, dval_r;
  logic             fval_p, lval_p;
  logic [DSIZE-1:0] data_r;

  logic             fval_rise, fval_fall, lval_fall;
  logic             enter_load;
  logic             qualify, wr_req, wr_ok;
  logic [DSIZE-1:0] wr_data_next;

  assign fval_rise = fval_r & ~fval_p;
  assign fval_fall = ~fval_r & fval_p;
  assign lval_fall = ~lval_r & lval_p;

  // LOAD is entered from vertical blank while armed, or straight from the end
  // of a frame when capture is still enabled.
  assign enter_load = ((state == S_WAIT_VB) && !fval_r) ||
                      ((state == S_ACTIVE) && fval_fall && iSTART);

  assign qualify = (state == S_ACTIVE) && fval_r && lval_r && dval_r;
  assign wr_req  = qualify && (oX_CNT < X_LIM) && (oY_CNT < Y_LIM);
  assign wr_ok   = wr_req && !iFIFO_FULL;

`ifdef SFW_TEST_PATTERN_EN
  logic [15:0] pattern;
  assign pattern      = {oY_CNT[7:0], oX_CNT[7:0]};
  assign wr_data_next = DSIZE'(pattern);
`else
  assign wr_data_next = data_r;
`endif

  assign oWR_LOAD = (state == S_LOAD);
  assign oBUSY    = (state != S_IDLE);

  // Input register plus one-cycle history for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fval_r <= 1'b0;
      lval_r <= 1'b0;
      dval_r <= 1'b0;
      data_r <= '0;
      fval_p <= 1'b0;
      lval_p <= 1'b0;
    end else begin
      fval_r <= iFVAL;
      lval_r <= iLVAL;
      dval_r <= iDVAL;
      data_r <= iDATA;
      fval_p <= fval_r;
      lval_p <= lval_r;
    end
  end

  // Frame sequencing FSM, load-pulse down-counter and frame counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      load_cnt   <= '0;
      oFRAME_CNT <= '0;
    end else begin
      if (enter_load)
        load_cnt <= LOAD_INIT;
      else if (state == S_LOAD && load_cnt != 4'd0)
        load_cnt <= load_cnt - 4'd1;

      case (state)
        S_IDLE:     if (iSTART) state <= S_WAIT_VB;
        S_WAIT_VB:  if (enter_load) state <= S_LOAD;
        S_LOAD:     if (load_cnt == 4'd0) state <= S_WAIT_SOF;
        S_WAIT_SOF: if (fval_rise) state <= S_ACTIVE;
        S_ACTIVE: begin
          if (fval_fall) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
            state      <= iSTART ? S_LOAD : S_IDLE;
          end
        end
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Pixel/line position counters, saturating at 2047; cleared on LOAD entry.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      oX_CNT <= '0;
      oY_CNT <= '0;
    end else if (enter_load) begin
      oX_CNT <= '0;
      oY_CNT <= '0;
    end else if (lval_fall) begin
      oX_CNT <= '0;
      if (oX_CNT != 11'd0 && oY_CNT != CNT_MAX)
        oY_CNT <= oY_CNT + 11'd1;
    end else if (qualify && oX_CNT != CNT_MAX) begin
      oX_CNT <= oX_CNT + 11'd1;
    end
  end

  // Write strobe/data register and sticky overflow flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      oWR       <= 1'b0;
      oWR_DATA  <= '0;
      oOVERFLOW <= 1'b0;
    end else begin
      oWR <= wr_ok;
      if (wr_ok)
        oWR_DATA <= wr_data_next;
      if (enter_load)
        oOVERFLOW <= 1'b0;
      else if (wr_req && iFIFO_FULL)
        oOVERFLOW <= 1'b1;
    end
  end

endmodule
